lcd1602_ctrlmod: RTL and testbench

//   Upstream sequencer for the LCD1602 byte-write function module. Holds a 2x16

---
 rtl/lcd1602_ctrlmod.sv | 175 +++++++++++++++++
 tb/tb_lcd1602_ctrlmod.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_ctrlmod.sv
// LCD1602 sequencer: holds a 2x16 frame buffer, sends the power-on command list,
// then streams address commands and characters to the byte writer over call/done.
module lcd1602_ctrlmod #(
  parameter bit INIT_EN = 1'b1,
  parameter int GAP_CYC = 4
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       iWr,
  input  logic [4:0] iAddr,
  input  logic [7:0] iChar,
  input  logic       iRefresh,
  output logic       oBusy,
  output logic       oCall,
  output logic       oRS,
  output logic [7:0] oDATA,
  input  logic       iDone
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ADDR1 = 3'd2,
    S_LINE1 = 3'd3,
    S_ADDR2 = 3'd4,
    S_LINE2 = 3'd5
  } state_e;

  localparam state_e RST_STATE = INIT_EN ? S_INIT : S_IDLE;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pend_q, pend_d;
  logic            call_q, call_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic [7:0]      buf_q [0:31];

  logic            issue_s, done_s, gap_end_s;
  logic [7:0]      byte_s;
  logic            byte_rs_s;

  // A byte goes out only once the previous handshake and its gap are both finished.
  assign issue_s   = (state_q != S_IDLE) && !call_q && (gap_q == '0);
  assign done_s    = call_q && iDone;
  assign gap_end_s = !call_q && (gap_q == GAP_ONE);

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q <= RST_STATE;
      idx_q   <= 4'd0;
      gap_q   <= '0;
      pend_q  <= 1'b1;
      call_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      call_q  <= call_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      if (iWr) buf_q[iAddr] <= iChar;
    end
  end

  // Sequencing advances at the end of each gap, so IDLE is reached only after the last gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q | iWr | iRefresh;
    if (done_s) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_ONE;
    end else begin
      gap_d = gap_q;
    end
    case (state_q)
      S_IDLE: begin
        // Requests landing while the refresh is being taken are covered by it.
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_ADDR1;
          idx_d   = 4'd0;
        end
      end
      S_INIT: begin
        if (gap_end_s) begin
          if (idx_q == 4'd3) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_ADDR1: if (gap_end_s) state_d = S_LINE1;
      S_LINE1: begin
        if (gap_end_s) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = S_ADDR2;
        end
      end
      S_ADDR2: if (gap_end_s) state_d = S_LINE2;
      S_LINE2: begin
        if (gap_end_s) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = RST_STATE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Byte selection and the registered handshake outputs.
  always_comb begin
    byte_s    = 8'h00;
    byte_rs_s = 1'b0;
    case (state_q)
      S_INIT: begin
        case (idx_q[1:0])
          2'd0:    byte_s = 8'h38;
          2'd1:    byte_s = 8'h0C;
          2'd2:    byte_s = 8'h06;
          default: byte_s = 8'h01;
        endcase
      end
      S_ADDR1: byte_s = 8'h80;
      S_LINE1: begin
        byte_s    = buf_q[{1'b0, idx_q}];
        byte_rs_s = 1'b1;
      end
      S_ADDR2: byte_s = 8'hC0;
      S_LINE2: begin
        byte_s    = buf_q[{1'b1, idx_q}];
        byte_rs_s = 1'b1;
      end
      default: byte_s = 8'h00;
    endcase
    call_d = call_q;
    rs_d   = rs_q;
    data_d = data_q;
    if (issue_s) begin
      call_d = 1'b1;
      rs_d   = byte_rs_s;
      data_d = byte_s;
    end else if (done_s) begin
      call_d = 1'b0;
    end else begin
      call_d = call_q;
    end
    busy_d = (state_d != S_IDLE) || pend_d;
  end

  assign oBusy = busy_q;
  assign oCall = call_q;
  assign oRS   = rs_q;
  assign oDATA = data_q;

endmodule

// File: tb/tb_lcd1602_ctrlmod.sv
// Directed bench for lcd1602_ctrlmod: a byte-writer model captures every handshake
// and the captured byte streams are compared against a shadow frame buffer.
module tb_lcd1602_ctrlmod;

  localparam int GAP = 4;

  logic       CLOCK = 1'b0;
  logic       RST = 1'b1;
  logic       iWr = 1'b0;
  logic [4:0] iAddr = 5'd0;
  logic [7:0] iChar = 8'd0;
  logic       iRefresh = 1'b0;
  logic       iDone;
  logic       oBusy, oCall, oRS;
  logic [7:0] oDATA;

  int checks = 0;
  int errors = 0;

  logic [8:0] cap[$];
  logic [8:0] exp_q[$];
  logic [7:0] shadow [0:31];

  int   dly = 3;
  bit   spur = 1'b0;
  int   stab_viol = 0;
  int   gap_viol = 0;
  int   busy_falls = 0;
  logic prev_call = 1'b0;
  logic prev_busy = 1'b0;
  bit   seen_fall = 1'b0;
  logic [8:0] held = 9'd0;
  int   cnt = 0;
  int   low_cnt = 0;

  typedef struct {
    logic [4:0] a0;
    logic [7:0] c0;
    logic [4:0] a1;
    logic [7:0] c1;
    int         p0;
    int         p1;
  } vec_t;

  vec_t vecs [4];

  lcd1602_ctrlmod #(.INIT_EN(1'b1), .GAP_CYC(GAP)) dut (
    .CLOCK    (CLOCK),
    .RST      (RST),
    .iWr      (iWr),
    .iAddr    (iAddr),
    .iChar    (iChar),
    .iRefresh (iRefresh),
    .oBusy    (oBusy),
    .oCall    (oCall),
    .oRS      (oRS),
    .oDATA    (oDATA),
    .iDone    (iDone)
  );

  always #5 CLOCK = ~CLOCK;

  // Byte-writer model: records each byte, answers after dly cycles, watches stability and gaps.
  initial begin
    iDone = 1'b0;
    forever begin
      @(negedge CLOCK);
      iDone = 1'b0;
      if (oCall) begin
        if (!prev_call) begin
          cap.push_back({oRS, oDATA});
          held = {oRS, oDATA};
          cnt  = 0;
          if (seen_fall && low_cnt < GAP) gap_viol++;
        end else if ({oRS, oDATA} !== held) begin
          stab_viol++;
        end
        cnt++;
        if (cnt == dly) iDone = 1'b1;
      end else begin
        if (prev_call) begin
          seen_fall = 1'b1;
          low_cnt   = 0;
        end
        low_cnt++;
        if (spur) begin
          iDone = 1'b1;
          spur  = 1'b0;
        end
      end
      if (RST) seen_fall = 1'b0;
      if (prev_busy && !oBusy) busy_falls++;
      prev_call = oCall;
      prev_busy = oBusy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [7:0] c);
    iWr = 1'b1; iAddr = a; iChar = c;
    @(negedge CLOCK);
    iWr = 1'b0;
    shadow[a] = c;
  endtask

  task automatic pulse_refresh();
    iRefresh = 1'b1;
    @(negedge CLOCK);
    iRefresh = 1'b0;
  endtask

  function automatic void add_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endfunction

  function automatic void add_refresh();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, shadow[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, shadow[i]});
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!oBusy && n < 50) begin @(negedge CLOCK); n++; end
    check({name, " busy rise"}, 32'(oBusy), 32'd1);
    n = 0;
    while (oBusy && n < 20000) begin @(negedge CLOCK); n++; end
    check({name, " busy fall"}, 32'(oBusy), 32'd0);
  endtask

  task automatic wait_cap(input int target, input string name);
    int n;
    n = 0;
    while (cap.size() < target && n < 5000) begin @(negedge CLOCK); n++; end
    check(name, 32'(cap.size() >= target), 32'd1);
  endtask

  // Compares n expected bytes (all of them when n<0) from captured position base on.
  task automatic cmp_stream(input string name, input int base, input int n);
    int num;
    num = (n < 0) ? exp_q.size() : n;
    if (n < 0) check({name, " length"}, 32'(cap.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < num; i++)
      check($sformatf("%s byte %0d", name, i),
            32'((base + i < cap.size()) ? cap[base + i] : 9'h000), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    int base;
    int bf0;
    int n;
    logic [7:0] old5;

    vecs[0] = '{5'd0,  8'h41, 5'd17, 8'h42, 1,  19};
    vecs[1] = '{5'd15, 8'h78, 5'd16, 8'h79, 16, 18};
    vecs[2] = '{5'd31, 8'h7E, 5'd0,  8'h30, 33, 1};
    vecs[3] = '{5'd5,  8'h21, 5'd21, 8'h22, 6,  23};
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;

    // 1: reset state, then init list and a refresh of spaces
    tick(3);
    check("reset oCall", 32'(oCall), 32'd0);
    check("reset oBusy", 32'(oBusy), 32'd0);
    check("reset oRS",   32'(oRS),   32'd0);
    check("reset oDATA", 32'(oDATA), 32'd0);
    add_init();
    add_refresh();
    RST = 1'b0;
    wait_idle("t1");
    cmp_stream("t1", 0, -1);

    // 2: two writes in idle merge into one refresh
    for (int v = 0; v < 4; v++) begin
      base = cap.size();
      host_wr(vecs[v].a0, vecs[v].c0);
      host_wr(vecs[v].a1, vecs[v].c1);
      add_refresh();
      wait_idle($sformatf("t2 v%0d", v));
      cmp_stream($sformatf("t2 v%0d", v), base, -1);
      check($sformatf("t2 v%0d p0", v), 32'(cap[base + vecs[v].p0]), 32'({1'b1, vecs[v].c0}));
      check($sformatf("t2 v%0d p1", v), 32'(cap[base + vecs[v].p1]), 32'({1'b1, vecs[v].c1}));
      tick(30);
      check($sformatf("t2 v%0d no extra", v), 32'(cap.size() - base), 32'd34);
    end

    // 3: several requests during one refresh give exactly one more
    base = cap.size();
    bf0 = busy_falls;
    add_refresh();
    add_refresh();
    pulse_refresh();
    tick(5);
    pulse_refresh();
    tick(20);
    host_wr(5'd3, shadow[3]);
    tick(40);
    host_wr(5'd20, shadow[20]);
    tick(40);
    host_wr(5'd31, shadow[31]);
    wait_idle("t3");
    cmp_stream("t3", base, -1);
    check("t3 busy falls", 32'(busy_falls - bf0), 32'd1);
    tick(30);
    check("t3 no third", 32'(cap.size() - base), 32'd68);

    // 4a: write to index 5 while index 5 is in flight -> old value now, new next pass
    base = cap.size();
    old5 = shadow[5];
    add_refresh();
    pulse_refresh();
    wait_cap(base + 7, "t4a reach idx5");
    host_wr(5'd5, 8'h5A);
    add_refresh();
    wait_idle("t4a");
    check("t4a old idx5", 32'(cap[base + 6]), 32'({1'b1, old5}));
    check("t4a new idx5", 32'(cap[base + 40]), 32'h15A);
    cmp_stream("t4a", base, -1);

    // 4b: write to index 5 while index 3 is in flight -> new value in the same pass
    base = cap.size();
    pulse_refresh();
    wait_cap(base + 5, "t4b reach idx3");
    host_wr(5'd5, 8'h59);
    add_refresh();
    add_refresh();
    wait_idle("t4b");
    check("t4b same pass", 32'(cap[base + 6]), 32'h159);
    cmp_stream("t4b", base, -1);

    // 5: slow iDone plus a spurious pulse in a gap and in idle
    dly = 200;
    base = cap.size();
    add_refresh();
    pulse_refresh();
    wait_cap(base + 3, "t5 start");
    n = 0;
    while (oCall && n < 300) begin @(negedge CLOCK); n++; end
    check("t5 call low", 32'(oCall), 32'd0);
    spur = 1'b1;
    wait_idle("t5");
    cmp_stream("t5", base, -1);
    check("t5 stability", 32'(stab_viol), 32'd0);
    check("t5 gap", 32'(gap_viol), 32'd0);
    spur = 1'b1;
    tick(20);
    check("t5 idle spur bytes", 32'(cap.size() - base), 32'd34);
    check("t5 idle spur busy", 32'(oBusy), 32'd0);
    dly = 3;

    // 6: reset in the middle of line 2
    base = cap.size();
    add_refresh();
    pulse_refresh();
    wait_cap(base + 21, "t6 reach line2");
    RST = 1'b1;
    @(negedge CLOCK);
    check("t6 oCall", 32'(oCall), 32'd0);
    check("t6 oBusy", 32'(oBusy), 32'd0);
    @(negedge CLOCK);
    RST = 1'b0;
    cmp_stream("t6 prefix", base, 21);
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    base = cap.size();
    add_init();
    add_refresh();
    wait_idle("t6");
    cmp_stream("t6 restart", base, -1);
    check("t6 stability", 32'(stab_viol), 32'd0);
    check("t6 gap", 32'(gap_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
